// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared types and defaults for the PE MAC lane and its job sequencer
package pe_pkg;

  localparam int PE_W_IN     = 8;
  localparam int PE_W_ACC    = 24;
  localparam int PE_LEN_W    = 10;
  localparam int PE_PIPE_LAT = 4;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    STREAM,
    DRAIN,
    RESP
  } pe_seq_state_t;

endpackage

// File: rtl/pe_mac_seq_if.sv
// rtl/pe_mac_seq_if.sv - command, operand and result handshakes between array controller and sequencer
interface pe_mac_seq_if #(
  parameter int W_IN  = 8,
  parameter int W_ACC = 24,
  parameter int LEN_W = 10
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len;
  logic             cmd_relu;

  logic             op_valid;
  logic             op_ready;
  logic [W_IN-1:0]  op_a;
  logic [W_IN-1:0]  op_b;

  logic             res_valid;
  logic             res_ready;
  logic [W_ACC-1:0] res_data;

  modport master (
    output cmd_valid, cmd_len, cmd_relu,
    input  cmd_ready,
    output op_valid, op_a, op_b,
    input  op_ready,
    input  res_valid, res_data,
    output res_ready
  );

  modport slave (
    input  cmd_valid, cmd_len, cmd_relu,
    output cmd_ready,
    input  op_valid, op_a, op_b,
    output op_ready,
    output res_valid, res_data,
    input  res_ready
  );

endinterface

// File: rtl/pe_mac_seq.sv
// rtl/pe_mac_seq.sv - dot-product job sequencer driving one pe_core MAC lane
// Optional early-abort support is enabled with PE_MAC_SEQ_ABORT_EN.
module pe_mac_seq
  import pe_pkg::*;
#(
  parameter int W_IN   = PE_W_IN,
  parameter int W_ACC  = PE_W_ACC,
  parameter int LEN_W  = PE_LEN_W,
  parameter int PE_LAT = PE_PIPE_LAT
) (
  input  logic             clk,
  input  logic             rst_n,
  pe_mac_seq_if.slave      ctl,
  output logic             pe_en,
  output logic             pe_mode_sel,
  output logic             pe_reg_reset,
  output logic [W_IN-1:0]  pe_a,
  output logic [W_IN-1:0]  pe_b,
  input  logic [W_ACC-1:0] pe_results,
`ifdef PE_MAC_SEQ_ABORT_EN
  input  logic             abort,
  output logic             res_aborted,
`endif
  output logic             busy
);

  localparam int DW = $clog2(PE_LAT + 1);

  pe_seq_state_t    state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    drn_q, drn_d;
  logic             relu_q, relu_d;
  logic [W_ACC-1:0] res_data_q, res_data_d;
  logic             op_hs;
  logic             abort_req;

`ifdef PE_MAC_SEQ_ABORT_EN
  logic aborted_q, aborted_d;
  assign abort_req   = abort && (state_q == CLR || state_q == STREAM);
  assign res_aborted = aborted_q;
`else
  assign abort_req = 1'b0;
`endif

  assign op_hs = (state_q == STREAM) && ctl.op_valid;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    drn_d      = drn_q;
    relu_d     = relu_q;
    res_data_d = res_data_q;
`ifdef PE_MAC_SEQ_ABORT_EN
    aborted_d  = aborted_q;
`endif
    case (state_q)
      IDLE: begin
        if (ctl.cmd_valid) begin
          len_d   = ctl.cmd_len;
          relu_d  = ctl.cmd_relu;
          state_d = CLR;
`ifdef PE_MAC_SEQ_ABORT_EN
          aborted_d = 1'b0;
`endif
        end
      end
      CLR: begin
        cnt_d = '0;
        if (abort_req) begin
          drn_d   = DW'(PE_LAT);
          state_d = DRAIN;
`ifdef PE_MAC_SEQ_ABORT_EN
          aborted_d = 1'b1;
`endif
        end else if (len_q == '0) begin
          res_data_d = '0;
          state_d    = RESP;
        end else begin
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (op_hs) cnt_d = cnt_q + LEN_W'(1);
        if ((op_hs && cnt_q == len_q - LEN_W'(1)) || abort_req) begin
          drn_d   = DW'(PE_LAT);
          state_d = DRAIN;
`ifdef PE_MAC_SEQ_ABORT_EN
          aborted_d = abort_req;
`endif
        end
      end
      DRAIN: begin
        drn_d = drn_q - DW'(1);
        // The PE pipeline has settled by the final drain cycle.
        if (drn_q == DW'(1)) begin
          res_data_d = pe_results;
          state_d    = RESP;
        end
      end
      RESP: begin
        if (ctl.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      drn_q      <= '0;
      relu_q     <= 1'b0;
      res_data_q <= '0;
`ifdef PE_MAC_SEQ_ABORT_EN
      aborted_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      drn_q      <= drn_d;
      relu_q     <= relu_d;
      res_data_q <= res_data_d;
`ifdef PE_MAC_SEQ_ABORT_EN
      aborted_q  <= aborted_d;
`endif
    end
  end

  assign ctl.cmd_ready = (state_q == IDLE);
  assign ctl.op_ready  = (state_q == STREAM);
  assign ctl.res_valid = (state_q == RESP);
  assign ctl.res_data  = res_data_q;
  assign busy          = (state_q != IDLE);

  // relu_q only changes on command accept, so mode_sel is constant across a job.
  assign pe_mode_sel  = relu_q;
  assign pe_reg_reset = (state_q == CLR);
  assign pe_en        = op_hs;
  assign pe_a         = pe_en ? ctl.op_a : '0;
  assign pe_b         = pe_en ? ctl.op_b : '0;

endmodule

// File: tb/tb_pe_mac_seq.sv
// tb/tb_pe_mac_seq.sv - scoreboard bench for pe_mac_seq with a behavioural PE lane
module tb_pe_mac_seq;

  localparam int W_IN  = 8;
  localparam int W_ACC = 24;
  localparam int LEN_W = 10;
  localparam int TMO   = 200;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pe_mac_seq_if #(.W_IN(W_IN), .W_ACC(W_ACC), .LEN_W(LEN_W)) ctl ();

  logic             pe_en, pe_mode_sel, pe_reg_reset, busy;
  logic [W_IN-1:0]  pe_a, pe_b;
  logic [W_ACC-1:0] pe_results;
`ifdef PE_MAC_SEQ_ABORT_EN
  logic abort = 1'b0;
  logic res_aborted;
`endif

  pe_mac_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ctl          (ctl),
    .pe_en        (pe_en),
    .pe_mode_sel  (pe_mode_sel),
    .pe_reg_reset (pe_reg_reset),
    .pe_a         (pe_a),
    .pe_b         (pe_b),
    .pe_results   (pe_results),
`ifdef PE_MAC_SEQ_ABORT_EN
    .abort        (abort),
    .res_aborted  (res_aborted),
`endif
    .busy         (busy)
  );

  // Behavioural PE: two product stages, accumulator, ReLU'd result register;
  // the clear is delayed two cycles; result final 4 cycles after the last pe_en.
  logic signed [8:0]       sa;
  logic signed [7:0]       sb;
  int                      prod_i;
  logic [W_ACC-1:0]        p1_prod, p2_prod, acc, res_r;
  logic                    p1_en, p2_en, p1_m, p2_m, acc_m, rr1, rr2;
  assign sa         = $signed({1'b0, pe_a});
  assign sb         = $signed(pe_b);
  assign prod_i     = int'(sa) * int'(sb);
  assign pe_results = res_r;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_prod <= '0; p2_prod <= '0; acc <= '0; res_r <= '0;
      p1_en <= 1'b0; p2_en <= 1'b0; p1_m <= 1'b0; p2_m <= 1'b0;
      acc_m <= 1'b0; rr1 <= 1'b0; rr2 <= 1'b0;
    end else begin
      p1_en   <= pe_en;
      p1_prod <= pe_en ? prod_i[W_ACC-1:0] : '0;
      p1_m    <= pe_mode_sel;
      rr1     <= pe_reg_reset;
      p2_en   <= p1_en;
      p2_prod <= p1_prod;
      p2_m    <= p1_m;
      rr2     <= rr1;
      if (rr2) acc <= '0;
      else if (p2_en) acc <= acc + p2_prod;
      if (p2_en) acc_m <= p2_m;
      res_r   <= (acc_m && acc[W_ACC-1]) ? '0 : acc;
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int en_cnt = 0;
  int rr_cnt = 0;
  logic [W_ACC:0] exp_q[$];
  logic [W_ACC:0] mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (pe_en) en_cnt <= en_cnt + 1;
    if (pe_reg_reset) rr_cnt <= rr_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=event within %0d cycles", name, TMO);
  endtask

  // Scoreboard monitor: every result handshake pops one expected entry.
  always @(negedge clk) begin
    if (rst_n && ctl.res_valid && ctl.res_ready) begin
      if (exp_q.size() == 0) begin
        timeout("sb_unexpected_result");
      end else begin
        mon_e = exp_q.pop_front();
        check("res_data", 32'(ctl.res_data), 32'(mon_e[W_ACC-1:0]));
`ifdef PE_MAC_SEQ_ABORT_EN
        check("res_aborted", 32'(res_aborted), 32'(mon_e[W_ACC]));
`endif
      end
    end
  end

  task automatic send_cmd(input int len, input logic relu, input logic push,
                          input logic [W_ACC:0] e, output int acc_cyc);
    int n = 0;
    if (push) exp_q.push_back(e);
    ctl.cmd_len   = LEN_W'(len);
    ctl.cmd_relu  = relu;
    ctl.cmd_valid = 1'b1;
    @(negedge clk);
    while (!ctl.cmd_ready && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (n >= TMO) timeout("cmd_accept");
    acc_cyc = cyc;
    @(posedge clk); #1;
    ctl.cmd_valid = 1'b0;
  endtask

  task automatic send_op(input logic [7:0] a, input logic [7:0] b, output int hs_cyc);
    int n = 0;
    ctl.op_valid = 1'b1;
    ctl.op_a     = a;
    ctl.op_b     = b;
    @(negedge clk);
    while (!ctl.op_ready && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (n >= TMO) timeout("op_accept");
    hs_cyc = cyc;
    @(posedge clk); #1;
    ctl.op_valid = 1'b0;
    ctl.op_a     = '0;
    ctl.op_b     = '0;
  endtask

  task automatic wait_res(output int rc);
    int n = 0;
    @(negedge clk);
    while (!ctl.res_valid && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (n >= TMO) timeout("res_valid");
    rc = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, c2, rc, h0, h, hs, en0, rr0;
    logic ok;
    ctl.cmd_valid = 1'b0; ctl.cmd_len = '0; ctl.cmd_relu = 1'b0;
    ctl.op_valid  = 1'b0; ctl.op_a = '0; ctl.op_b = '0;
    ctl.res_ready = 1'b1;

    #12;
    check("rst_ctl", {ctl.cmd_ready, ctl.op_ready, ctl.res_valid, busy}, 4'b1000);
    check("rst_pe", {pe_en, pe_mode_sel, pe_reg_reset, pe_a, pe_b}, 0);
    check("rst_res_data", 32'(ctl.res_data), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Job 1: raw sum 10*-2 + 5*3 + 255*1 = 250, result 5 cycles after last op.
    send_cmd(3, 1'b0, 1'b1, {1'b0, 24'd250}, c);
    send_op(8'd10, 8'hFE, h0);
    check("t1_first_op_lat", h0 - c, 2);
    send_op(8'd5, 8'd3, h);
    send_op(8'd255, 8'd1, h);
    wait_res(rc);
    check("t1_res_lat", rc - h, 5);
    @(posedge clk); #1;

    // Job 2: ReLU of 100*-5 + 1*7 = -493 -> 0.
    send_cmd(2, 1'b1, 1'b1, {1'b0, 24'd0}, c);
    check("t2_mode_sel", 32'(pe_mode_sel), 1);
    send_op(8'd100, 8'hFB, h);
    send_op(8'd1, 8'd7, h);
    wait_res(rc);
    @(posedge clk); #1;

    // Job 3: empty job.
    en0 = en_cnt;
    rr0 = rr_cnt;
    send_cmd(0, 1'b0, 1'b1, {1'b0, 24'd0}, c);
    wait_res(rc);
    check("t3_res_lat", rc - c, 2);
    @(posedge clk); #1;
    check("t3_pe_en_count", en_cnt - en0, 0);
    check("t3_reg_reset_count", rr_cnt - rr0, 1);

    // Job 4a (3*3=9) held unconsumed while job 4b waits for cmd_ready.
    ctl.res_ready = 1'b0;
    send_cmd(1, 1'b0, 1'b1, {1'b0, 24'd9}, c);
    send_op(8'd3, 8'd3, h);
    wait_res(rc);
    @(posedge clk); #1;
    exp_q.push_back({1'b0, 24'd4});
    ctl.cmd_len = LEN_W'(2); ctl.cmd_relu = 1'b0; ctl.cmd_valid = 1'b1;
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (ctl.cmd_ready || !ctl.res_valid || ctl.res_data != 24'd9) ok = 1'b0;
    end
    check("t4_cmd_blocked", 32'(ok), 1);
    @(posedge clk); #1;
    ctl.res_ready = 1'b1;
    @(negedge clk);
    hs = cyc;
    @(posedge clk); #1;
    ctl.res_ready = 1'b0;
    c2 = 0;
    @(negedge clk);
    while (!ctl.cmd_ready && c2 < TMO) begin
      @(negedge clk);
      c2++;
    end
    if (c2 >= TMO) timeout("t4_cmd_accept");
    check("t4_accept_after_hs", cyc - hs, 1);
    @(posedge clk); #1;
    ctl.cmd_valid = 1'b0;
    send_op(8'd1, 8'd2, h);
    repeat (1) @(posedge clk);
    #1;
    send_op(8'd1, 8'd2, h);
    wait_res(rc);
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (!ctl.res_valid || ctl.res_data != 24'd4) ok = 1'b0;
    end
    check("t4_res_held", 32'(ok), 1);
    @(posedge clk); #1;
    ctl.res_ready = 1'b1;
    @(posedge clk); #1;

    // Job 5: async reset after 2 of 4 pairs, then a fresh job 7*-1 = -7.
    send_cmd(4, 1'b1, 1'b0, '0, c);
    send_op(8'd1, 8'd1, h);
    send_op(8'd2, 8'd2, h);
    ctl.op_valid = 1'b1; ctl.op_a = 8'd5; ctl.op_b = 8'd5;
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_rst_ctl", {ctl.cmd_ready, ctl.op_ready, ctl.res_valid, busy}, 4'b1000);
    check("t5_rst_pe", {pe_en, pe_mode_sel, pe_reg_reset, pe_a, pe_b}, 0);
    check("t5_rst_res_data", 32'(ctl.res_data), 0);
    ctl.op_valid = 1'b0; ctl.op_a = '0; ctl.op_b = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_cmd(1, 1'b0, 1'b1, {1'b0, 24'hFFFFF9}, c);
    send_op(8'd7, 8'hFF, h);
    wait_res(rc);
    check("t5_res_lat", rc - h, 5);
    @(posedge clk); #1;

`ifdef PE_MAC_SEQ_ABORT_EN
    // Job 6: abort after (4,4),(1,1) -> partial 17 flagged aborted.
    send_cmd(5, 1'b0, 1'b1, {1'b1, 24'd17}, c);
    send_op(8'd4, 8'd4, h);
    send_op(8'd1, 8'd1, h);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("t6_op_ready_after_abort", 32'(ctl.op_ready), 0);
    wait_res(rc);
    @(posedge clk); #1;
`endif

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_mac_seq.md
# pe_mac_seq

Job sequencer that drives one `pe_core` MAC lane from the array controller side. It accepts a dot-product command (length, activation mode), clears the PE accumulator, and streams operand pairs into the PE over a valid/ready operand port. It waits out the PE pipeline, captures the final PE `results`, and returns it on a valid/ready result port. It is the initiator for the PE's pe_en/reg_reset/mode_sel interface and sits between the operand buffers and each PE instance.

## Interface
- W_IN, 8, operand width (matches PE)
- W_ACC, 24, accumulator/result width (matches PE)
- LEN_W, 10, width of job length field (max 2^LEN_W-1 pairs)
- PE_LAT, 4, drain cycles from last pe_en until PE `results` holds final sum
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid / cmd_ready  in / out  1  job handshake
- cmd_len  in  LEN_W  number of operand pairs (0 allowed)
- cmd_relu  in  1  0: raw result, 1: ReLU result
- op_valid / op_ready  in / out  1  operand handshake
- op_a  in  W_IN  unsigned operand
- op_b  in  W_IN  signed operand
- pe_en  out  1  to PE pe_en
- pe_mode_sel  out  1  to PE mode_sel
- pe_reg_reset  out  1  to PE reg_reset
- pe_a / pe_b  out  W_IN  to PE a_mul / b_mul
- pe_results  in  W_ACC  from PE results (signed)
- res_valid / res_ready  out / in  1  result handshake
- res_data  out  W_ACC  signed final result
- busy  out  1  state != IDLE

## Operation
- States: IDLE, CLR, STREAM, DRAIN, RESP.
- IDLE: cmd_ready=1. On cmd_valid, latch len and relu, then go to CLR.
- CLR (1 cycle): pe_reg_reset=1. Next state is STREAM if len>0, else RESP with res_data=0.
- STREAM: op_ready=1; pe_en=op_valid; pe_a=op_a; pe_b=op_b (combinational, gated by state). Each handshake increments a pair counter. The handshake where count==len-1 moves to DRAIN. Gaps in op_valid leave the PE accumulator held.
- DRAIN: down-counter loaded with PE_LAT. On the last drain cycle, pe_results is registered into res_data. Then go to RESP.
- RESP: res_valid=1 and res_data stable until res_ready, then IDLE.
- pe_mode_sel = latched relu for the whole job, held constant from CLR through DRAIN. The PE aligns mode_sel with pe_en, so it must not change mid-job.
- pe_en, pe_reg_reset, op_ready are 0 outside STREAM/CLR respectively. pe_a/pe_b are 0 when pe_en=0.
- Arithmetic is owned by the PE: the product is unsigned × signed, and the accumulator wraps modulo 2^W_ACC. This block passes pe_results through unmodified.

## Timing
- Reset values: cmd_ready=1 (IDLE), op_ready=0, pe_en=0, pe_mode_sel=0, pe_reg_reset=0, pe_a=pe_b=0, res_valid=0, res_data=0, busy=0.
- Cmd accepted at edge of cycle C. CLR is cycle C+1. The first possible pe_en is cycle C+2.
- CLR always precedes the first pe_en by at least 1 cycle. This is required because the PE's delayed clear overrides an accumulate in the same cycle.
- Last pe_en in cycle L: DRAIN covers L+1..L+PE_LAT, capture occurs at the end of L+PE_LAT, and res_valid rises in L+PE_LAT+1 (L+5 by default).
- len=0: res_valid rises in cycle C+2 with res_data=0.
- Next cmd is accepted no earlier than the cycle after the res handshake. Back-to-back jobs therefore never overlap in the PE pipeline.
- Async reset mid-job: all state returns to IDLE and outputs go to reset values immediately. The shared rst_n clears the PE. The partial job is discarded without a result.

## Configuration
- PE_MAC_SEQ_ABORT_EN defined: adds input `abort` (1 bit) and output `res_aborted` (1 bit, reset 0).
  - `abort` high in CLR or STREAM stops operand consumption (op_ready=0 from the next cycle) and goes to DRAIN.
  - RESP then returns the partial sum with res_aborted=1.
  - `abort` is ignored in IDLE, DRAIN and RESP.
- PE_MAC_SEQ_ABORT_EN undefined: neither port exists and jobs always run to len.

## Structure
- Shared package `pe_pkg`:
  - typedef enum `pe_seq_state_t` (IDLE, CLR, STREAM, DRAIN, RESP)
  - constant `PE_PIPE_LAT`=4, used as PE_LAT default
  - W_IN/W_ACC defaults
- No sub-module. The FSM, pair counter and drain counter are inline. Integration test instantiates `pe_core` alongside.

## Test plan
- len=3, relu=0, ops (10,-2),(5,3),(255,1) back-to-back -> res_data=250, res_valid exactly 5 cycles after the last op handshake.
- len=2, relu=1, ops (100,-5),(1,7) -> raw sum -493, res_data=0.
- len=0 -> pe_en never high, pe_reg_reset pulsed once, res_data=0 at C+2.
- Two jobs: job1 (3,3) -> 9, job2 (2,2) with op_valid toggling every other cycle and res_ready low 5 cycles -> job2 result 4 (no carry-over), cmd_ready low until job1 result is taken.
- rst_n low mid-STREAM after 2 of 4 pairs -> all outputs at reset values; new job len=1 (7,-1) -> -7.
- With PE_MAC_SEQ_ABORT_EN: len=5, abort after 2 pairs (4,4),(1,1) -> res_data=17, res_aborted=1.
